id_ex_hazard_stage: RTL and testbench
=====================================

Name: id_ex_hazard_stage

Overview:
- ID/EX pipeline register of the pipelined RV32I core, combined with load-use hazard detection and bubble/flush insertion.
- Its EX-side outputs (rs1_ex, rs2_ex, opcode_ex, rd_ex, control) drive the EX-stage forwarding unit and ALU muxes.
- It generates the PC and IF/ID write enables, and keeps saturating stall and flush counters for performance debug.

Parameters:
- SIZE, 32, datapath width (register data, immediate, PC).
- CNT_WIDTH, 16, width of each saturating performance counter.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  branch/jump taken; the instruction in ID is squashed.
- hold  in  1  global pipeline freeze (e.g. memory busy).
- opcode_id  in  7  opcode of the instruction in ID.
- rs1_id, rs2_id, rd_id  in  5 each  register fields of the instruction in ID.
- rs1_data_id, rs2_data_id  in  SIZE each  register file read data.
- imm_id  in  SIZE  sign-extended immediate.
- pc_id  in  SIZE  PC of the instruction in ID.
- ctrl_id  in  ctrl_t (8)  decoded control bundle.
- opcode_ex  out  7  registered opcode.
- rs1_ex, rs2_ex, rd_ex  out  5 each  registered register fields.
- rs1_data_ex, rs2_data_ex, imm_ex, pc_ex  out  SIZE each  registered data.
- ctrl_ex  out  ctrl_t (8)  registered control bundle.
- pc_write  out  1  PC update enable (combinational).
- if_id_write  out  1  IF/ID register update enable (combinational).
- stall_cnt, flush_cnt  out  CNT_WIDTH each  saturating event counters.

Behaviour:
- Reset: every EX output, stall_cnt and flush_cnt are 0 on the first edge with rst=1. Reset overrides all other inputs and aborts any pending stall. pc_write and if_id_write are 1 while rst=1.
- Source usage by opcode_id:
  - uses_rs1 = R 0110011, I-ALU 0010011, load 0000011, S 0100011, B 1100011, JALR 1100111.
  - uses_rs2 = R, S, B only.
  - LUI, AUIPC, JAL and unknown opcodes use no sources.
- load_use = ctrl_ex.mem_read && rd_ex!=0 && ((uses_rs1 && rd_ex==rs1_id) || (uses_rs2 && rd_ex==rs2_id)).
- Per-cycle priority: rst > flush > hold > load_use > normal.
  - flush: load a bubble into ID/EX; pc_write=1, if_id_write=1; flush_cnt++; load_use is ignored and stall_cnt is not incremented.
  - hold: ID/EX keeps its contents; pc_write=0, if_id_write=0; no counter change.
  - load_use: load a bubble into ID/EX; pc_write=0, if_id_write=0; stall_cnt++.
  - normal: capture all *_id inputs into the *_ex registers; pc_write=1, if_id_write=1.
- Bubble contents: ctrl=0, opcode=7'b0000000, rd=rs1=rs2=0, data/imm/pc=0. The forwarding unit therefore sees no writer and no source.
- Latency: 1 cycle from ID inputs to EX outputs.
- A load-use stall lasts exactly 1 cycle. On the next cycle the load has moved on and load_use deasserts, since rd_ex of the bubble is 0.
- Two consecutive loads feeding each other stall once per dependent pair.
- Counters saturate at all-ones and never wrap.
- pc_write and if_id_write depend only on rst, flush, hold, the current ID/EX contents and the ID fields.

Decomposition:
- Package riscv_pipe_pkg contains:
  - ctrl_t packed struct: reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, alu_op[1:0].
  - Opcode localparams OP_R, OP_I, OP_LOAD, OP_S, OP_B, OP_JALR, OP_LUI, OP_AUIPC, OP_JAL.
  - Constants CTRL_BUBBLE and OP_BUBBLE.
- One sub-module, sat_counter (parameter WIDTH; inputs clk, rst, inc; output count), instantiated twice.
- The load-use detection logic stays inline.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> all EX outputs 0, both counters 0, pc_write=1.
- Pass-through: add x3,x1,x2 (opcode 0110011, rs1=1, rs2=2, rd=3, pc=0x40) -> next cycle rs1_ex=1, rs2_ex=2, rd_ex=3, pc_ex=0x40, ctrl_ex equals ctrl_id.
- Load-use on rs1: lw x5 in EX (mem_read=1, rd_ex=5), add x6,x5,x7 in ID -> pc_write=0 and if_id_write=0 for 1 cycle, bubble in EX, stall_cnt=1; add enters EX on the following cycle.
- No false stalls:
  - lw to x0 followed by add x6,x0,x7 -> no stall.
  - lw x5 followed by addi x6,x1,5 with rs2 field=5 -> no stall, since I-type does not use rs2.
- Flush versus hazard: load_use and flush both true -> bubble, pc_write=1, flush_cnt=1, stall_cnt unchanged.
- Hold and saturation:
  - hold=1 for 3 cycles -> EX outputs unchanged, pc_write=0.
  - With CNT_WIDTH=2, 5 load-use events -> stall_cnt=3.

Source files
------------

// File: rtl/id_ex_hazard_stage_pkg.sv
// riscv_pipe_pkg: types and constants shared by the ID/EX hazard stage.
//   ctrl_t          decoded control bundle, 8 bits, reg_write in the MSB
//   OP_*            RV32I major opcodes the stage recognises
//   CTRL_BUBBLE,
//   OP_BUBBLE       contents loaded into ID/EX to insert a bubble
//   stage_action_t  per-cycle decision of the stage (debug visibility)
//   uses_rs1/uses_rs2  whether an opcode actually reads rs1 / rs2
package riscv_pipe_pkg;

   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       alu_src;
      logic       branch;
      logic [1:0] alu_op;
   } ctrl_t;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   localparam ctrl_t      CTRL_BUBBLE = '0;
   localparam logic [6:0] OP_BUBBLE   = 7'b0000000;

   // What the stage does this cycle, in priority order reset > flush >
   // hold > stall > normal.
   typedef enum logic [2:0] {
      ACT_NORMAL = 3'd0,
      ACT_STALL  = 3'd1,
      ACT_HOLD   = 3'd2,
      ACT_FLUSH  = 3'd3,
      ACT_RESET  = 3'd4
   } stage_action_t;

   function automatic logic uses_rs1(input logic [6:0] opcode);
      case (opcode)
         OP_R, OP_I, OP_LOAD, OP_S, OP_B, OP_JALR: uses_rs1 = 1'b1;
         OP_LUI, OP_AUIPC, OP_JAL:                uses_rs1 = 1'b0;
         default:                                 uses_rs1 = 1'b0;
      endcase
   endfunction

   // I-type, load and JALR carry immediate bits in the rs2 field, so only
   // R, S and B really read rs2.
   function automatic logic uses_rs2(input logic [6:0] opcode);
      case (opcode)
         OP_R, OP_S, OP_B: uses_rs2 = 1'b1;
         default:          uses_rs2 = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/id_ex_hazard_stage_if.sv
// Interface bundling the ID-side inputs and EX-side outputs of the ID/EX
// hazard stage.
//   master : decode/control side, drives flush, hold and the *_id fields
//   slave  : the stage, drives the *_ex fields, pc_write, if_id_write,
//            the two saturating counters and the action debug output
//
// Flow control: there is no valid/ready pair. pc_write and if_id_write are
// combinational enables meaning "the fetch side may advance this cycle";
// when low, the PC and IF/ID register must keep their value so the same
// instruction is presented again in ID on the next cycle.
interface id_ex_hazard_stage_if #(
   parameter int SIZE      = 32,
   parameter int CNT_WIDTH = 16
);
   import riscv_pipe_pkg::*;

   logic                 flush;
   logic                 hold;
   logic [6:0]           opcode_id;
   logic [4:0]           rs1_id;
   logic [4:0]           rs2_id;
   logic [4:0]           rd_id;
   logic [SIZE-1:0]      rs1_data_id;
   logic [SIZE-1:0]      rs2_data_id;
   logic [SIZE-1:0]      imm_id;
   logic [SIZE-1:0]      pc_id;
   ctrl_t                ctrl_id;

   logic [6:0]           opcode_ex;
   logic [4:0]           rs1_ex;
   logic [4:0]           rs2_ex;
   logic [4:0]           rd_ex;
   logic [SIZE-1:0]      rs1_data_ex;
   logic [SIZE-1:0]      rs2_data_ex;
   logic [SIZE-1:0]      imm_ex;
   logic [SIZE-1:0]      pc_ex;
   ctrl_t                ctrl_ex;
   logic                 pc_write;
   logic                 if_id_write;
   logic [CNT_WIDTH-1:0] stall_cnt;
   logic [CNT_WIDTH-1:0] flush_cnt;
   stage_action_t        action;

   modport master (
      output flush, hold, opcode_id, rs1_id, rs2_id, rd_id,
             rs1_data_id, rs2_data_id, imm_id, pc_id, ctrl_id,
      input  opcode_ex, rs1_ex, rs2_ex, rd_ex, rs1_data_ex, rs2_data_ex,
             imm_ex, pc_ex, ctrl_ex, pc_write, if_id_write,
             stall_cnt, flush_cnt, action
   );

   modport slave (
      input  flush, hold, opcode_id, rs1_id, rs2_id, rd_id,
             rs1_data_id, rs2_data_id, imm_id, pc_id, ctrl_id,
      output opcode_ex, rs1_ex, rs2_ex, rd_ex, rs1_data_ex, rs2_data_ex,
             imm_ex, pc_ex, ctrl_ex, pc_write, if_id_write,
             stall_cnt, flush_cnt, action
   );

endinterface

// File: rtl/id_ex_hazard_stage_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
//   clk   : clock, count updates on rising edge
//   rst   : synchronous active-high clear
//   inc   : add one this cycle (ignored once saturated)
//   count : current count
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != MAX)) begin
         count_d = count_q + ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/id_ex_hazard_stage.sv
// id_ex_hazard_stage: ID/EX pipeline register of the RV32I core with
// load-use hazard detection, bubble insertion on stall or flush, and
// saturating stall/flush event counters.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of id_ex_hazard_stage_if
//              in  flush, hold, opcode/rs1/rs2/rd/data/imm/pc/ctrl _id
//              out registered *_ex fields, pc_write, if_id_write,
//                  stall_cnt, flush_cnt, action (current decision)
module id_ex_hazard_stage
   import riscv_pipe_pkg::*;
#(
   parameter int SIZE      = 32,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   id_ex_hazard_stage_if.slave  bus
);

   logic [6:0]      opcode_q,   opcode_d;
   logic [4:0]      rs1_q,      rs1_d;
   logic [4:0]      rs2_q,      rs2_d;
   logic [4:0]      rd_q,       rd_d;
   logic [SIZE-1:0] rs1_data_q, rs1_data_d;
   logic [SIZE-1:0] rs2_data_q, rs2_data_d;
   logic [SIZE-1:0] imm_q,      imm_d;
   logic [SIZE-1:0] pc_q,       pc_d;
   ctrl_t           ctrl_q,     ctrl_d;

   logic            load_use;
   stage_action_t   action;
   logic            advance;
   logic [CNT_WIDTH-1:0] stall_cnt;
   logic [CNT_WIDTH-1:0] flush_cnt;

   // A load sitting in EX whose destination is a source actually read by
   // the instruction in ID. x0 is never a real dependency. Only the
   // current ID/EX contents and ID fields feed this, so the bubble that a
   // stall inserts (rd=0, mem_read=0) clears it on the following cycle.
   always_comb begin
      load_use = ctrl_q.mem_read && (rd_q != 5'd0) &&
                 ((uses_rs1(bus.opcode_id) && (rd_q == bus.rs1_id)) ||
                  (uses_rs2(bus.opcode_id) && (rd_q == bus.rs2_id)));
   end

   always_comb begin
      if (rst) begin
         action = ACT_RESET;
      end else if (bus.flush) begin
         action = ACT_FLUSH;
      end else if (bus.hold) begin
         action = ACT_HOLD;
      end else if (load_use) begin
         action = ACT_STALL;
      end else begin
         action = ACT_NORMAL;
      end
   end

   // Fetch may advance unless we freeze (hold) or replay the ID
   // instruction (stall). A flush redirects fetch, so it must advance.
   assign advance = (action == ACT_NORMAL) || (action == ACT_FLUSH) ||
                    (action == ACT_RESET);

   always_comb begin
      opcode_d   = opcode_q;
      rs1_d      = rs1_q;
      rs2_d      = rs2_q;
      rd_d       = rd_q;
      rs1_data_d = rs1_data_q;
      rs2_data_d = rs2_data_q;
      imm_d      = imm_q;
      pc_d       = pc_q;
      ctrl_d     = ctrl_q;
      case (action)
         ACT_NORMAL: begin
            opcode_d   = bus.opcode_id;
            rs1_d      = bus.rs1_id;
            rs2_d      = bus.rs2_id;
            rd_d       = bus.rd_id;
            rs1_data_d = bus.rs1_data_id;
            rs2_data_d = bus.rs2_data_id;
            imm_d      = bus.imm_id;
            pc_d       = bus.pc_id;
            ctrl_d     = bus.ctrl_id;
         end
         ACT_STALL, ACT_FLUSH, ACT_RESET: begin
            // Bubble: no writer and no sources for the forwarding unit.
            opcode_d   = OP_BUBBLE;
            rs1_d      = 5'd0;
            rs2_d      = 5'd0;
            rd_d       = 5'd0;
            rs1_data_d = '0;
            rs2_data_d = '0;
            imm_d      = '0;
            pc_d       = '0;
            ctrl_d     = CTRL_BUBBLE;
         end
         default: ; // ACT_HOLD keeps the register contents
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         opcode_q   <= OP_BUBBLE;
         rs1_q      <= 5'd0;
         rs2_q      <= 5'd0;
         rd_q       <= 5'd0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         pc_q       <= '0;
         ctrl_q     <= CTRL_BUBBLE;
      end else begin
         opcode_q   <= opcode_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         rd_q       <= rd_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         imm_q      <= imm_d;
         pc_q       <= pc_d;
         ctrl_q     <= ctrl_d;
      end
   end

   sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (action == ACT_STALL),
      .count (stall_cnt)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (action == ACT_FLUSH),
      .count (flush_cnt)
   );

   assign bus.opcode_ex   = opcode_q;
   assign bus.rs1_ex      = rs1_q;
   assign bus.rs2_ex      = rs2_q;
   assign bus.rd_ex       = rd_q;
   assign bus.rs1_data_ex = rs1_data_q;
   assign bus.rs2_data_ex = rs2_data_q;
   assign bus.imm_ex      = imm_q;
   assign bus.pc_ex       = pc_q;
   assign bus.ctrl_ex     = ctrl_q;
   assign bus.pc_write    = advance;
   assign bus.if_id_write = advance;
   assign bus.stall_cnt   = stall_cnt;
   assign bus.flush_cnt   = flush_cnt;
   assign bus.action      = action;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Bench for id_ex_hazard_stage, built with CNT_WIDTH=2 so counter
// saturation is reachable in a few events.
module tb_id_ex_hazard_stage;
   import riscv_pipe_pkg::*;

   localparam int SIZE = 32;
   localparam int CW   = 2;

   localparam logic [1:0] K_CAP  = 2'd0; // EX captures this row's ID inputs
   localparam logic [1:0] K_BUB  = 2'd1; // EX becomes all zeros
   localparam logic [1:0] K_HOLD = 2'd2; // EX keeps previous contents

   localparam logic [7:0] C_R   = 8'h82; // reg_write, alu_op=10
   localparam logic [7:0] C_LD  = 8'hD8; // reg_write, mem_read, mem_to_reg, alu_src
   localparam logic [7:0] C_I   = 8'h8B; // reg_write, alu_src, alu_op=11
   localparam logic [7:0] C_LUI = 8'h88; // reg_write, alu_src
   localparam logic [7:0] C_S   = 8'h28; // mem_write, alu_src
   localparam logic [7:0] C_JAL = 8'h80; // reg_write

   typedef struct {
      logic        rst;
      logic        flush;
      logic        hold;
      logic [6:0]  op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [7:0]  ctrl;
      logic [31:0] pc;
      logic        exp_pcw;
      logic [1:0]  kind;
      logic [1:0]  exp_stall;
      logic [1:0]  exp_flush;
   } vec_t;

   logic clk;
   logic rst;
   int   tests;
   int   fails;

   // expected EX contents
   logic [6:0]  e_op;
   logic [4:0]  e_rs1, e_rs2, e_rd;
   logic [7:0]  e_ctrl;
   logic [31:0] e_d1, e_d2, e_imm, e_pc;

   vec_t vecs[$];

   id_ex_hazard_stage_if #(.SIZE(SIZE), .CNT_WIDTH(CW)) bus ();

   id_ex_hazard_stage #(.SIZE(SIZE), .CNT_WIDTH(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mk(input logic fl, input logic ho, input logic [6:0] op,
                               input logic [4:0] r1, input logic [4:0] r2,
                               input logic [4:0] rd, input logic [7:0] c,
                               input logic [31:0] pc, input logic pcw,
                               input logic [1:0] k, input logic [1:0] st,
                               input logic [1:0] ff);
      vec_t v;
      v.rst = 1'b0; v.flush = fl; v.hold = ho; v.op = op;
      v.rs1 = r1; v.rs2 = r2; v.rd = rd; v.ctrl = c; v.pc = pc;
      v.exp_pcw = pcw; v.kind = k; v.exp_stall = st; v.exp_flush = ff;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_ex(input string tag, input logic [1:0] st, input logic [1:0] ff);
      chk({tag, " opcode_ex"},   32'(bus.opcode_ex),   32'(e_op));
      chk({tag, " rs1_ex"},      32'(bus.rs1_ex),      32'(e_rs1));
      chk({tag, " rs2_ex"},      32'(bus.rs2_ex),      32'(e_rs2));
      chk({tag, " rd_ex"},       32'(bus.rd_ex),       32'(e_rd));
      chk({tag, " ctrl_ex"},     32'(bus.ctrl_ex),     32'(e_ctrl));
      chk({tag, " rs1_data_ex"}, bus.rs1_data_ex,      e_d1);
      chk({tag, " rs2_data_ex"}, bus.rs2_data_ex,      e_d2);
      chk({tag, " imm_ex"},      bus.imm_ex,           e_imm);
      chk({tag, " pc_ex"},       bus.pc_ex,            e_pc);
      chk({tag, " stall_cnt"},   32'(bus.stall_cnt),   32'(st));
      chk({tag, " flush_cnt"},   32'(bus.flush_cnt),   32'(ff));
   endtask

   // driver: present one row, check the fetch enables mid-cycle, clock it,
   // then check the registered outputs against the expected model
   task automatic apply(input vec_t v, input int idx);
      string tag;
      logic [31:0] d1, d2, im;
      tag = $sformatf("v%0d", idx);
      d1  = v.pc ^ 32'hA5A5_0000;
      d2  = v.pc ^ 32'h5A5A_0000;
      im  = ~v.pc;
      @(negedge clk);
      rst             = v.rst;
      bus.flush       = v.flush;
      bus.hold        = v.hold;
      bus.opcode_id   = v.op;
      bus.rs1_id      = v.rs1;
      bus.rs2_id      = v.rs2;
      bus.rd_id       = v.rd;
      bus.ctrl_id     = v.ctrl;
      bus.pc_id       = v.pc;
      bus.rs1_data_id = d1;
      bus.rs2_data_id = d2;
      bus.imm_id      = im;
      #1;
      chk({tag, " pc_write"},    32'(bus.pc_write),    32'(v.exp_pcw));
      chk({tag, " if_id_write"}, 32'(bus.if_id_write), 32'(v.exp_pcw));
      @(posedge clk);
      #1;
      if (v.rst || v.kind == K_BUB) begin
         e_op = 7'd0; e_rs1 = 5'd0; e_rs2 = 5'd0; e_rd = 5'd0; e_ctrl = 8'd0;
         e_d1 = '0; e_d2 = '0; e_imm = '0; e_pc = '0;
      end else if (v.kind == K_CAP) begin
         e_op = v.op; e_rs1 = v.rs1; e_rs2 = v.rs2; e_rd = v.rd; e_ctrl = v.ctrl;
         e_d1 = d1; e_d2 = d2; e_imm = im; e_pc = v.pc;
      end
      chk_ex(tag, v.exp_stall, v.exp_flush);
   endtask

   initial begin
      vec_t v;
      tests = 0;
      fails = 0;

      // stimulus table: fl ho opcode rs1 rs2 rd ctrl pc | pcw kind stall flush
      vecs.push_back(mk(0,0,OP_R,   5'd1, 5'd2, 5'd3, C_R,  32'h40,1,K_CAP, 2'd0,2'd0)); // add x3,x1,x2
      vecs.push_back(mk(0,0,OP_LOAD,5'd1, 5'd0, 5'd5, C_LD, 32'h44,1,K_CAP, 2'd0,2'd0)); // lw x5
      vecs.push_back(mk(0,0,OP_R,   5'd5, 5'd7, 5'd6, C_R,  32'h48,0,K_BUB, 2'd1,2'd0)); // add x6,x5,x7 stalls
      vecs.push_back(mk(0,0,OP_R,   5'd5, 5'd7, 5'd6, C_R,  32'h48,1,K_CAP, 2'd1,2'd0)); // replayed, enters EX
      vecs.push_back(mk(0,0,OP_LOAD,5'd1, 5'd0, 5'd0, C_LD, 32'h4C,1,K_CAP, 2'd1,2'd0)); // lw x0
      vecs.push_back(mk(0,0,OP_R,   5'd0, 5'd7, 5'd6, C_R,  32'h50,1,K_CAP, 2'd1,2'd0)); // add x6,x0,x7 no stall
      vecs.push_back(mk(0,0,OP_LOAD,5'd1, 5'd0, 5'd5, C_LD, 32'h54,1,K_CAP, 2'd1,2'd0)); // lw x5
      vecs.push_back(mk(0,0,OP_I,   5'd1, 5'd5, 5'd6, C_I,  32'h58,1,K_CAP, 2'd1,2'd0)); // addi, rs2 field=5
      vecs.push_back(mk(0,0,OP_LOAD,5'd1, 5'd0, 5'd5, C_LD, 32'h5C,1,K_CAP, 2'd1,2'd0)); // lw x5
      vecs.push_back(mk(0,0,OP_R,   5'd7, 5'd5, 5'd6, C_R,  32'h60,0,K_BUB, 2'd2,2'd0)); // rs2 hazard
      vecs.push_back(mk(0,0,OP_R,   5'd7, 5'd5, 5'd6, C_R,  32'h60,1,K_CAP, 2'd2,2'd0));
      vecs.push_back(mk(0,0,OP_LOAD,5'd1, 5'd0, 5'd5, C_LD, 32'h64,1,K_CAP, 2'd2,2'd0)); // lw x5
      vecs.push_back(mk(1,0,OP_R,   5'd5, 5'd1, 5'd8, C_R,  32'h68,1,K_BUB, 2'd2,2'd1)); // flush beats hazard
      vecs.push_back(mk(0,0,OP_LOAD,5'd2, 5'd0, 5'd9, C_LD, 32'h6C,1,K_CAP, 2'd2,2'd1)); // lw x9
      vecs.push_back(mk(0,0,OP_LUI, 5'd9, 5'd9, 5'd10,C_LUI,32'h70,1,K_CAP, 2'd2,2'd1)); // lui: no sources
      vecs.push_back(mk(0,1,OP_R,   5'd1, 5'd2, 5'd3, C_R,  32'h74,0,K_HOLD,2'd2,2'd1)); // hold x3
      vecs.push_back(mk(0,1,OP_R,   5'd4, 5'd5, 5'd6, C_R,  32'h78,0,K_HOLD,2'd2,2'd1));
      vecs.push_back(mk(0,1,OP_R,   5'd7, 5'd8, 5'd9, C_R,  32'h7C,0,K_HOLD,2'd2,2'd1));
      vecs.push_back(mk(0,0,OP_LOAD,5'd1, 5'd0, 5'd11,C_LD, 32'h80,1,K_CAP, 2'd2,2'd1)); // lw x11
      vecs.push_back(mk(0,1,OP_R,   5'd11,5'd2, 5'd12,C_R,  32'h84,0,K_HOLD,2'd2,2'd1)); // hold beats hazard
      vecs.push_back(mk(0,0,OP_R,   5'd11,5'd2, 5'd12,C_R,  32'h84,0,K_BUB, 2'd3,2'd1)); // 3rd stall
      vecs.push_back(mk(0,0,OP_R,   5'd11,5'd2, 5'd12,C_R,  32'h84,1,K_CAP, 2'd3,2'd1));
      vecs.push_back(mk(0,0,OP_LOAD,5'd1, 5'd0, 5'd12,C_LD, 32'h88,1,K_CAP, 2'd3,2'd1)); // lw x12
      vecs.push_back(mk(0,0,OP_R,   5'd12,5'd3, 5'd13,C_R,  32'h8C,0,K_BUB, 2'd3,2'd1)); // 4th stall, saturated
      vecs.push_back(mk(0,0,OP_R,   5'd12,5'd3, 5'd13,C_R,  32'h8C,1,K_CAP, 2'd3,2'd1));
      vecs.push_back(mk(0,0,OP_LOAD,5'd1, 5'd0, 5'd13,C_LD, 32'h90,1,K_CAP, 2'd3,2'd1)); // lw x13
      vecs.push_back(mk(0,0,OP_S,   5'd2, 5'd13,5'd0, C_S,  32'h94,0,K_BUB, 2'd3,2'd1)); // sw x13: 5th stall
      vecs.push_back(mk(0,0,OP_S,   5'd2, 5'd13,5'd0, C_S,  32'h94,1,K_CAP, 2'd3,2'd1));
      vecs.push_back(mk(1,1,OP_R,   5'd1, 5'd2, 5'd3, C_R,  32'h98,1,K_BUB, 2'd3,2'd2)); // flush beats hold
      vecs.push_back(mk(1,0,OP_R,   5'd1, 5'd2, 5'd3, C_R,  32'h9C,1,K_BUB, 2'd3,2'd3));
      vecs.push_back(mk(1,0,OP_R,   5'd1, 5'd2, 5'd3, C_R,  32'hA0,1,K_BUB, 2'd3,2'd3)); // flush saturated
      vecs.push_back(mk(0,0,OP_LOAD,5'd1, 5'd0, 5'd5, C_LD, 32'hA4,1,K_CAP, 2'd3,2'd3)); // lw x5
      vecs.push_back(mk(0,0,OP_LOAD,5'd5, 5'd0, 5'd6, C_LD, 32'hA8,0,K_BUB, 2'd3,2'd3)); // lw x6,0(x5)
      vecs.push_back(mk(0,0,OP_LOAD,5'd5, 5'd0, 5'd6, C_LD, 32'hA8,1,K_CAP, 2'd3,2'd3)); // single stall
      vecs.push_back(mk(0,0,OP_JAL, 5'd6, 5'd6, 5'd1, C_JAL,32'hAC,1,K_CAP, 2'd3,2'd3)); // jal: no sources

      // reset: two cycles with random ID inputs
      rst = 1'b1;
      for (int c = 0; c < 2; c++) begin
         bus.flush       = 1'($urandom_range(0, 1));
         bus.hold        = 1'($urandom_range(0, 1));
         bus.opcode_id   = 7'($urandom);
         bus.rs1_id      = 5'($urandom);
         bus.rs2_id      = 5'($urandom);
         bus.rd_id       = 5'($urandom);
         bus.ctrl_id     = 8'($urandom);
         bus.pc_id       = $urandom;
         bus.rs1_data_id = $urandom;
         bus.rs2_data_id = $urandom;
         bus.imm_id      = $urandom;
         #1;
         chk("reset pc_write",    32'(bus.pc_write),    32'd1);
         chk("reset if_id_write", 32'(bus.if_id_write), 32'd1);
         @(posedge clk);
         #1;
         e_op = 7'd0; e_rs1 = 5'd0; e_rs2 = 5'd0; e_rd = 5'd0; e_ctrl = 8'd0;
         e_d1 = '0; e_d2 = '0; e_imm = '0; e_pc = '0;
         chk_ex($sformatf("reset%0d", c), 2'd0, 2'd0);
         @(negedge clk);
      end

      foreach (vecs[i]) apply(vecs[i], i);

      // reset arriving while a load-use stall is pending clears everything;
      // the dependent add then flows straight in behind the reset bubble
      apply(mk(0,0,OP_LOAD,5'd1,5'd0,5'd5,C_LD,32'hC0,1,K_CAP,2'd3,2'd3), 100);
      v = mk(0,0,OP_R,5'd5,5'd7,5'd6,C_R,32'hC4,1,K_BUB,2'd0,2'd0);
      v.rst = 1'b1;
      apply(v, 101);
      apply(mk(0,0,OP_R,5'd5,5'd7,5'd6,C_R,32'hC4,1,K_CAP,2'd0,2'd0), 102);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
